// File: rtl/mc_main_control.sv
// rtl/mc_main_control.sv - multi-cycle main control FSM for the homework CPU datapath
// Moore-style decode from state; only FETCH (ack) and BRANCH (zero) look at inputs.
module mc_main_control #(
    parameter logic [2:0] ALUOP_RTYPE = 3'b000,
    parameter logic [2:0] ALUOP_MEM   = 3'b010,
    parameter logic [2:0] ALUOP_BR    = 3'b001,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] aluop,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB_ALU = 4'd3,
        S_ADDR   = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWR  = 4'd6,
        S_WB_MEM = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_next;
    logic [3:0] op_q;
    logic [7:0] tmo_cnt, tmo_cnt_next;
    logic       in_mem;
    logic       tmo_hit;

    logic       mem_req_d, mem_we_d, ir_write_d, pc_write_d, reg_write_d;

    assign in_mem  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign tmo_hit = in_mem && !mem_ack && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            op_q    <= 4'd0;
            tmo_cnt <= 8'd0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_cnt_next;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Counter is held at zero outside the mem states, so entry always starts from zero.
    always_comb begin
        state_next   = state;
        tmo_cnt_next = 8'd0;
        if (in_mem && !mem_ack) begin
            tmo_cnt_next = tmo_cnt + 8'd1;
        end
        case (state)
            S_FETCH: begin
                if (mem_ack) begin
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                if (opcode <= 4'd6) begin
                    state_next = S_EXEC;
                end else if ((opcode == 4'd8) || (opcode == 4'd9)) begin
                    state_next = S_ADDR;
                end else if ((opcode == 4'd10) || (opcode == 4'd11)) begin
                    state_next = S_BRANCH;
                end else if (opcode == 4'd12) begin
                    state_next = S_JUMP;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC:   state_next = S_WB_ALU;
            S_WB_ALU: state_next = S_FETCH;
            S_ADDR:   state_next = (op_q == 4'd8) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ack) begin
                    state_next = S_WB_MEM;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_MEMWR: begin
                if (mem_ack) begin
                    state_next = S_FETCH;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_WB_MEM: state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        iord        = 1'b0;
        ir_write_d  = 1'b0;
        pc_write_d  = 1'b0;
        pc_src      = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        aluop       = ALUOP_MEM;
        reg_dst     = 1'b0;
        reg_write_d = 1'b0;
        mem_to_reg  = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req_d  = 1'b1;
                alu_src_b  = 2'd1;
                ir_write_d = mem_ack;
                pc_write_d = mem_ack;
            end
            S_DECODE: begin
                alu_src_b = 2'd2;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                if (op_q == 4'd0) begin
                    alu_src_b = 2'd0;
                    aluop     = ALUOP_RTYPE;
                end else begin
                    alu_src_b = 2'd2;
                    aluop     = op_q[2:0];
                end
            end
            S_WB_ALU: begin
                reg_write_d = 1'b1;
                reg_dst     = (op_q == 4'd0);
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_req_d = 1'b1;
                iord      = 1'b1;
            end
            S_MEMWR: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
                iord      = 1'b1;
            end
            S_WB_MEM: begin
                reg_write_d = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                aluop      = ALUOP_BR;
                pc_src     = 2'd1;
                pc_write_d = zero ^ op_q[0];
            end
            S_JUMP: begin
                pc_src     = 2'd2;
                pc_write_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Strobes are gated by reset so nothing fires while rst_n is held low.
    assign mem_req   = mem_req_d   & rst_n;
    assign mem_we    = mem_we_d    & rst_n;
    assign ir_write  = ir_write_d  & rst_n;
    assign pc_write  = pc_write_d  & rst_n;
    assign reg_write = reg_write_d & rst_n;
    assign illegal   = (state == S_TRAP);
    assign state_o   = state;

endmodule

// File: tb/tb_mc_main_control.sv
// tb/tb_mc_main_control.sv - randomized self-checking bench for mc_main_control
// Expected per-cycle control vectors are built from instruction-level timing rules.
module tb_mc_main_control;

    localparam int TO = 15;
    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC = 4'd2, ST_WB_ALU = 4'd3,
                           ST_ADDR = 4'd4, ST_MEMRD = 4'd5, ST_MEMWR = 4'd6, ST_WB_MEM = 4'd7,
                           ST_BRANCH = 4'd8, ST_JUMP = 4'd9, ST_TRAP = 4'd10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_dst, reg_write;
    logic       mem_to_reg, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] aluop;
    logic [3:0] state_o;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] aluop;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } ctl_t;

    ctl_t obs;
    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                  aluop, reg_dst, reg_write, mem_to_reg, illegal};

    mc_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .aluop(aluop), .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    bit   fresh;
    ctl_t e_ctl[$];
    logic [3:0] e_st[$];
    logic e_ack[$];
    logic [3:0] e_op[$];
    logic e_z[$];

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.aluop = 3'b010;
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic void push(ctl_t c, logic [3:0] s, logic a, logic [3:0] op, logic z);
        e_ctl.push_back(c);
        e_st.push_back(s);
        e_ack.push_back(a);
        e_op.push_back(op);
        e_z.push_back(z);
    endfunction

    function automatic void push_trap(int n);
        ctl_t c = idle();
        c.illegal = 1'b1;
        repeat (n) push(c, ST_TRAP, rbit(), rop(), rbit());
    endfunction

    // Returns 1 when the instruction ends up in the trap state.
    function automatic bit build(logic [3:0] op, int fw, int dw, logic z);
        ctl_t c;
        logic [3:0] mst;
        c = idle();
        c.mem_req = 1'b1;
        c.alu_src_b = 2'd1;
        if (fw >= TO) begin
            repeat (TO) push(c, ST_FETCH, 1'b0, rop(), rbit());
            push_trap(4);
            return 1'b1;
        end
        repeat (fw) push(c, ST_FETCH, 1'b0, rop(), rbit());
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        push(c, ST_FETCH, 1'b1, rop(), rbit());
        c = idle();
        c.alu_src_b = 2'd2;
        push(c, ST_DECODE, rbit(), op, rbit());
        if (op <= 4'd6) begin
            c = idle();
            c.alu_src_a = 1'b1;
            c.alu_src_b = (op == 4'd0) ? 2'd0 : 2'd2;
            c.aluop = (op == 4'd0) ? 3'b000 : op[2:0];
            push(c, ST_EXEC, rbit(), rop(), rbit());
            c = idle();
            c.reg_write = 1'b1;
            c.reg_dst = (op == 4'd0);
            push(c, ST_WB_ALU, rbit(), rop(), rbit());
        end else if (op == 4'd8 || op == 4'd9) begin
            c = idle();
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
            push(c, ST_ADDR, rbit(), rop(), rbit());
            c = idle();
            c.mem_req = 1'b1;
            c.iord = 1'b1;
            c.mem_we = (op == 4'd9);
            mst = (op == 4'd9) ? ST_MEMWR : ST_MEMRD;
            if (dw >= TO) begin
                repeat (TO) push(c, mst, 1'b0, rop(), rbit());
                push_trap(4);
                return 1'b1;
            end
            repeat (dw) push(c, mst, 1'b0, rop(), rbit());
            push(c, mst, 1'b1, rop(), rbit());
            if (op == 4'd8) begin
                c = idle();
                c.reg_write = 1'b1;
                c.mem_to_reg = 1'b1;
                push(c, ST_WB_MEM, rbit(), rop(), rbit());
            end
        end else if (op == 4'd10 || op == 4'd11) begin
            c = idle();
            c.alu_src_a = 1'b1;
            c.aluop = 3'b001;
            c.pc_src = 2'd1;
            c.pc_write = (op == 4'd10) ? z : !z;
            push(c, ST_BRANCH, rbit(), rop(), z);
        end else if (op == 4'd12) begin
            c = idle();
            c.pc_src = 2'd2;
            c.pc_write = 1'b1;
            push(c, ST_JUMP, rbit(), rop(), rbit());
        end else begin
            push_trap(4);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input ctl_t exp, input logic [3:0] est);
        tests++;
        assert ({obs, state_o} === {exp, est}) else begin
            fails++;
            $error("FAIL %s: observed ctl=%h state=%0d, expected ctl=%h state=%0d",
                   tag, obs, state_o, exp, est);
        end
    endtask

    task automatic clear_q();
        e_ctl.delete();
        e_st.delete();
        e_ack.delete();
        e_op.delete();
        e_z.delete();
    endtask

    task automatic run(input string tag, input int limit);
        int n;
        n = (limit < 0) ? e_ctl.size() : limit;
        for (int i = 0; i < n; i++) begin
            if (!(fresh && i == 0)) @(posedge clk);
            #1;
            mem_ack = e_ack[i];
            opcode = e_op[i];
            zero = e_z[i];
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), e_ctl[i], e_st[i]);
        end
        fresh = 1'b0;
        clear_q();
    endtask

    task automatic do_reset();
        ctl_t r;
        r = idle();
        r.alu_src_b = 2'd1;
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("reset_hold", r, ST_FETCH);
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        @(negedge clk);
        check("reset_ack_ignored", r, ST_FETCH);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        rst_n = 1'b1;
        fresh = 1'b1;
    endtask

    initial begin
        bit   trapped;
        ctl_t r;
        int   fw, dw;
        logic [3:0] op;

        fresh = 1'b1;
        do_reset();

        void'(build(4'd0, 0, 0, 1'b0));  run("rtype_zero_wait", -1);
        void'(build(4'd8, 1, 3, 1'b0));  run("lw_3wait", -1);
        void'(build(4'd10, 0, 0, 1'b1)); run("beq_taken", -1);
        void'(build(4'd11, 2, 0, 1'b1)); run("bne_not_taken", -1);
        void'(build(4'd5, 0, 0, 1'b0));  run("itype_0101", -1);
        void'(build(4'd12, 0, 0, 1'b0)); run("jump", -1);
        void'(build(4'd9, 0, TO - 1, 1'b0)); run("sw_wait_limit", -1);

        void'(build(4'd15, 0, 0, 1'b0)); run("illegal_1111", -1);
        do_reset();
        void'(build(4'd9, 0, TO, 1'b0)); run("sw_timeout", -1);
        do_reset();
        void'(build(4'd0, TO, 0, 1'b0)); run("fetch_timeout", -1);
        do_reset();

        void'(build(4'd9, 1, 6, 1'b0));
        run("sw_pre_abort", 6);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        r = idle();
        r.alu_src_b = 2'd1;
        check("sw_abort_immediate", r, ST_FETCH);
        @(negedge clk);
        check("sw_abort_held", r, ST_FETCH);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fresh = 1'b1;
        void'(build(4'd1, 0, 0, 1'b0)); run("after_abort", -1);

        for (int k = 0; k < 60; k++) begin
            op = rop();
            fw = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 3);
            dw = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 3);
            trapped = build(op, fw, dw, rbit());
            run($sformatf("rand%0d_op%0d", k, op), -1);
            if (trapped) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
